// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative EX-stage divider: state encodings,
// ready/start/stall level names and the operand width used by default.
package div_unit_pkg;

   localparam int DIV_WIDTH = 32;

   // Divider control states
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   // Result-valid levels
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // Start-request levels driven by the EX stage
   localparam logic DivStart = 1'b1;
   localparam logic DivStop  = 1'b0;

   // Stall-request levels shared with the stall controller
   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // Stall vector the controller applies while EX requests a stall (IF..EX frozen)
   localparam logic [5:0] StallBusEx = 6'b001111;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU. Holds the pipeline through
// stallreq_for_ex while a division is outstanding and returns
// {remainder, quotient} for the HI/LO write path.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 div_start,
   input  logic                 div_signed,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [WIDTH-1:0]     divisor,
   input  logic                 annul,
   output logic                 stallreq_for_ex,
   output logic                 div_ready,
   output logic [2*WIDTH-1:0]   div_result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   div_state_e           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   w_q, w_d;
   logic [WIDTH-1:0]     dvsr_q, dvsr_d;
   logic                 q_neg_q, q_neg_d;
   logic                 r_neg_q, r_neg_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic                 dividend_neg_s;
   logic                 divisor_neg_s;
   logic [WIDTH-1:0]     dividend_abs_s;
   logic [WIDTH-1:0]     divisor_abs_s;
   logic [2*WIDTH-1:0]   w_shift_s;
   logic                 w_carry_s;
   logic                 fits_s;
   logic [WIDTH-1:0]     w_diff_s;
   logic [2*WIDTH-1:0]   w_iter_s;
   logic [WIDTH-1:0]     quot_fix_s;
   logic [WIDTH-1:0]     rem_fix_s;

   // Operand magnitudes and signs for the start cycle; 0x80000000 stays
   // 0x80000000 and is then treated as an unsigned magnitude.
   always_comb begin
      dividend_neg_s = div_signed & dividend[WIDTH-1];
      divisor_neg_s  = div_signed & divisor[WIDTH-1];
      if (dividend_neg_s) begin
         dividend_abs_s = ~dividend + WIDTH'(1);
      end else begin
         dividend_abs_s = dividend;
      end
      if (divisor_neg_s) begin
         divisor_abs_s = ~divisor + WIDTH'(1);
      end else begin
         divisor_abs_s = divisor;
      end
   end

   // One restoring step: shift, trial-compare, subtract and set the quotient bit.
   // The bit shifted out of the top is kept as a carry so divisors above
   // 2^(WIDTH-1) still compare correctly.
   always_comb begin
      w_shift_s = {w_q[2*WIDTH-2:0], 1'b0};
      w_carry_s = w_q[2*WIDTH-1];
      fits_s    = w_carry_s | (w_shift_s[2*WIDTH-1:WIDTH] >= dvsr_q);
      w_diff_s  = w_shift_s[2*WIDTH-1:WIDTH] - dvsr_q;
      if (fits_s) begin
         w_iter_s = {w_diff_s, w_shift_s[WIDTH-1:1], 1'b1};
      end else begin
         w_iter_s = w_shift_s;
      end
   end

   // Sign correction applied to the final iteration's quotient and remainder.
   always_comb begin
      if (q_neg_q) begin
         quot_fix_s = ~w_iter_s[WIDTH-1:0] + WIDTH'(1);
      end else begin
         quot_fix_s = w_iter_s[WIDTH-1:0];
      end
      if (r_neg_q) begin
         rem_fix_s = ~w_iter_s[2*WIDTH-1:WIDTH] + WIDTH'(1);
      end else begin
         rem_fix_s = w_iter_s[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state and datapath update for the divider FSM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      w_d      = w_q;
      dvsr_d   = dvsr_q;
      q_neg_d  = q_neg_q;
      r_neg_d  = r_neg_q;
      result_d = result_q;
      case (state_q)
         DivFree: begin
            if ((div_start == DivStart) && !annul) begin
               dvsr_d  = divisor_abs_s;
               q_neg_d = dividend_neg_s ^ divisor_neg_s;
               r_neg_d = dividend_neg_s;
               w_d     = {{WIDTH{1'b0}}, dividend_abs_s};
               cnt_d   = {CW{1'b0}};
               if (divisor == {WIDTH{1'b0}}) begin
                  state_d = DivByZero;
               end else begin
                  state_d = DivOn;
               end
            end else begin
               state_d = DivFree;
            end
         end
         DivByZero: begin
            state_d  = DivEnd;
            result_d = {2*WIDTH{1'b0}};
         end
         DivOn: begin
            if (annul) begin
               state_d  = DivFree;
               result_d = {2*WIDTH{1'b0}};
               cnt_d    = {CW{1'b0}};
            end else begin
               w_d   = w_iter_s;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d  = DivEnd;
                  result_d = {rem_fix_s, quot_fix_s};
               end else begin
                  state_d = DivOn;
               end
            end
         end
         DivEnd: begin
            state_d = DivFree;
         end
         default: begin
            state_d = DivFree;
         end
      endcase
   end

   // State and datapath registers; an asynchronous reset discards any partial result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= DivFree;
         cnt_q    <= {CW{1'b0}};
         w_q      <= {2*WIDTH{1'b0}};
         dvsr_q   <= {WIDTH{1'b0}};
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= {2*WIDTH{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         w_q      <= w_d;
         dvsr_q   <= dvsr_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
      end
   end

   // Stall request and ready flag decoded from the registered state.
   always_comb begin
      if ((div_start == DivStart) && (state_q != DivEnd)) begin
         stallreq_for_ex = Stop;
      end else begin
         stallreq_for_ex = NoStop;
      end
      if (state_q == DivEnd) begin
         div_ready = DivResultReady;
      end else begin
         div_ready = DivResultNotReady;
      end
   end

   assign div_result = result_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// operands checked against a plain-arithmetic reference.
module tb_div_unit;

   logic         clk;
   logic         rst_n;
   logic         div_start;
   logic         div_signed;
   logic [31:0]  dividend;
   logic [31:0]  divisor;
   logic         annul;
   logic         stallreq_for_ex;
   logic         div_ready;
   logic [63:0]  div_result;

   int n_checks = 0;
   int n_fail   = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .div_start       (div_start),
      .div_signed      (div_signed),
      .dividend        (dividend),
      .divisor         (divisor),
      .annul           (annul),
      .stallreq_for_ex (stallreq_for_ex),
      .div_ready       (div_ready),
      .div_result      (div_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: {remainder, quotient} from ordinary integer division.
   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (!sgn) return {a % b, a / b};
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] exp;
      int lat, stall_cyc, n;
      bit done;
      exp = ref_div(sgn, a, b);
      lat = (b == 32'd0) ? 2 : 33;
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = sgn;
      dividend   = a;
      divisor    = b;
      annul      = 1'b0;
      #1;
      stall_cyc = stallreq_for_ex ? 1 : 0;
      done = 0;
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         // operands are only sampled on the start cycle
         dividend   = $urandom;
         divisor    = $urandom;
         div_signed = 1'($urandom);
         #1;
         n++;
         if (div_ready) done = 1;
         else if (stallreq_for_ex) stall_cyc++;
      end
      if (!done) begin
         check_val({tag, " timeout"}, 64'd0, 64'd1);
      end else begin
         check_val({tag, " latency"}, 64'(n), 64'(lat));
         check_val({tag, " result"}, div_result, exp);
         check_val({tag, " stall_cycles"}, 64'(stall_cyc), 64'(lat));
         check_val({tag, " stall_in_end"}, 64'(stallreq_for_ex), 64'd0);
      end
      @(negedge clk);
      div_start = 1'b0;
      #1;
      check_val({tag, " ready_drop"}, 64'(div_ready), 64'd0);
      check_val({tag, " result_hold"}, div_result, exp);
   endtask

   initial begin
      rst_n      = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      dividend   = 32'd0;
      divisor    = 32'd0;
      annul      = 1'b0;
      #12;
      check_val("reset ready", 64'(div_ready), 64'd0);
      check_val("reset result", div_result, 64'd0);
      check_val("reset stall", 64'(stallreq_for_ex), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_val("idle stall", 64'(stallreq_for_ex), 64'd0);

      run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
      check_val("divu_100_7 literal", div_result, {32'd2, 32'd14});
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
      check_val("div_m7_2 literal", div_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
      check_val("div_7_m2 literal", div_result, {32'd1, 32'hFFFF_FFFD});
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
      check_val("div_min_m1 literal", div_result, {32'd0, 32'h8000_0000});
      run_div(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
      run_div(1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, "divu_big_divisor");
      run_div(1'b0, 32'd1234, 32'd0, "div_by_zero");

      // annul during ON at T+10
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         #1;
         if (k == 10) check_val("annul no_ready", 64'(div_ready), 64'd0);
      end
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      div_start = 1'b0;
      #1;
      check_val("annul ready", 64'(div_ready), 64'd0);
      check_val("annul result", div_result, 64'd0);
      run_div(1'b0, 32'd50, 32'd6, "after_annul");

      // annul in FREE suppresses the start (divisor 0 would finish in 2 cycles)
      @(negedge clk);
      div_start = 1'b1; annul = 1'b1; dividend = 32'd5; divisor = 32'd0;
      @(negedge clk);
      div_start = 1'b0; annul = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         check_val("annul_free no_ready", 64'(div_ready), 64'd0);
      end
      check_val("annul_free result", div_result, ref_div(1'b0, 32'd50, 32'd6));

      // asynchronous reset in the middle of a division
      @(negedge clk);
      div_start = 1'b1; div_signed = 1'b0; dividend = 32'd777; divisor = 32'd5;
      for (int k = 0; k < 5; k++) @(negedge clk);
      rst_n = 1'b0;
      div_start = 1'b0;
      #1;
      check_val("rst_mid ready", 64'(div_ready), 64'd0);
      check_val("rst_mid result", div_result, 64'd0);
      check_val("rst_mid stall", 64'(stallreq_for_ex), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_div(1'b0, 32'd9, 32'd3, "after_reset");
      check_val("after_reset literal", div_result, {32'd0, 32'd3});

      // randomized operands, biased toward sign and magnitude corners
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a, b;
         logic s;
         a = $urandom;
         b = $urandom;
         s = 1'($urandom);
         case ($urandom_range(0, 5))
            0: b = $urandom_range(1, 15);
            1: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
            2: a = 32'h8000_0000;
            3: b = 32'd0;
            default: ;
         endcase
         run_div(s, a, b, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_div_unit
